// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures combinational imem reads into a
// small prefetch FIFO, and presents {pc, instr} to decode as a valid/ready stream.
module fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [15:0]              imem_pc,
    input  logic [15:0]              imem_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_pc,
    output logic [15:0]              out_instr,
    input  logic                     redirect,
    input  logic [15:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [15:0]   fetch_pc;
    logic [15:0]   pc_mem    [DEPTH];
    logic [15:0]   instr_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Redirect masks valid combinationally so decode sees the redirect cycle as a kill.
    assign out_valid = (count != '0) && !redirect;
    assign pop       = out_valid && out_ready;
    assign push      = !redirect && ((count < CW'(DEPTH)) || pop);

    assign imem_pc   = fetch_pc;
    assign out_pc    = pc_mem[rd_ptr];
    assign out_instr = instr_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pc_mem    <= '{default: '0};
            instr_mem <= '{default: '0};
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= fetch_pc;
                instr_mem[wr_ptr] <= imem_instr;
                wr_ptr            <= wr_ptr + PW'(1);
                fetch_pc          <= fetch_pc + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // Simultaneous push and pop leave occupancy unchanged.
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected PCs per stream segment,
// popped and compared on every accepted handshake, plus cycle-exact spot checks.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [15:0] imem_pc;
    logic [15:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [1:0]  count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] sb[$];

    fetch_unit #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_pc     (imem_pc),
        .imem_instr  (imem_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .count       (count)
    );

    // Memory model: combinational read, instr derived from the word address.
    assign imem_instr = imem_pc ^ 16'hA5A5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Discard pending expectations and load the in-order PC stream starting at start.
    task automatic load(input logic [15:0] start);
        sb.delete();
        for (int i = 0; i < 64; i++) sb.push_back(start + 16'(i));
    endtask

    task automatic settle();
        #2;
    endtask

    // Score any handshake in the current cycle, then move just past the next edge.
    task automatic advance();
        logic [15:0] exp_pc;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_bad++;
                $error("FAIL sb_empty: accepted pc %h, expected no entry", out_pc);
            end
            if (sb.size() > 0) begin
                exp_pc = sb.pop_front();
                chk("stream_pc", 32'(out_pc), 32'(exp_pc));
                chk("stream_instr", 32'(out_instr), 32'(exp_pc ^ 16'hA5A5));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            settle();
            advance();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        out_ready   = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        settle();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_imem_pc", 32'(imem_pc), 32'h0000);
        chk("rst_out_pc", 32'(out_pc), 32'h0000);
        chk("rst_out_instr", 32'(out_instr), 32'h0000);

        // Streaming: cycle R, then one instruction per cycle with count steady at 1.
        reset     = 1'b0;
        out_ready = 1'b1;
        load(16'h0000);
        settle();
        chk("R_imem_pc", 32'(imem_pc), 32'h0000);
        chk("R_valid", 32'(out_valid), 32'd0);
        advance();
        settle();
        chk("R1_valid", 32'(out_valid), 32'd1);
        chk("R1_out_pc", 32'(out_pc), 32'h0000);
        chk("R1_count", 32'(count), 32'd1);
        advance();
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_count", 32'(count), 32'd1);
            advance();
        end

        // Backpressure from a fresh reset: ready low through R+5.
        reset     = 1'b1;
        out_ready = 1'b0;
        run(1);
        reset = 1'b0;
        load(16'h0000);
        run(1);
        settle();
        chk("bp_R1_count", 32'(count), 32'd1);
        chk("bp_R1_imem_pc", 32'(imem_pc), 32'h0001);
        advance();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("bp_full_count", 32'(count), 32'd2);
            chk("bp_hold_imem_pc", 32'(imem_pc), 32'h0002);
            chk("bp_full_valid", 32'(out_valid), 32'd1);
            advance();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("bp_release_valid", 32'(out_valid), 32'd1);
            chk("bp_release_pc", 32'(out_pc), 32'(i));
            chk("bp_release_count", 32'(count), 32'd2);
            advance();
        end

        // Redirect while full of PCs 4,5.
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        load(16'h0040);
        settle();
        chk("rdf_count_before", 32'(count), 32'd2);
        chk("rdf_head_pc", 32'(out_pc), 32'h0004);
        chk("rdf_valid_T", 32'(out_valid), 32'd0);
        advance();
        redirect = 1'b0;
        settle();
        chk("rdf_count_T1", 32'(count), 32'd0);
        chk("rdf_imem_pc_T1", 32'(imem_pc), 32'h0040);
        chk("rdf_valid_T1", 32'(out_valid), 32'd0);
        advance();
        settle();
        chk("rdf_valid_T2", 32'(out_valid), 32'd1);
        chk("rdf_out_pc_T2", 32'(out_pc), 32'h0040);
        advance();
        run(2);

        // Wrap through 16'hFFFF.
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        load(16'hFFFF);
        run(1);
        redirect = 1'b0;
        settle();
        chk("wrap_imem_pc", 32'(imem_pc), 32'hFFFF);
        advance();
        settle();
        chk("wrap_first_pc", 32'(out_pc), 32'hFFFF);
        chk("wrap_next_imem_pc", 32'(imem_pc), 32'h0000);
        advance();
        run(3);

        // Back-to-back redirects: the second target wins.
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        sb.delete();
        run(1);
        redirect_pc = 16'h0020;
        load(16'h0020);
        settle();
        chk("b2b_valid_2nd", 32'(out_valid), 32'd0);
        advance();
        redirect = 1'b0;
        settle();
        chk("b2b_imem_pc", 32'(imem_pc), 32'h0020);
        chk("b2b_valid", 32'(out_valid), 32'd0);
        advance();
        settle();
        chk("b2b_first_pc", 32'(out_pc), 32'h0020);
        advance();
        run(3);

        // Reset mid-stream with count 2 and a coincident redirect.
        out_ready = 1'b0;
        run(1);
        settle();
        chk("mid_count_full", 32'(count), 32'd2);
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h1234;
        load(16'h0000);
        advance();
        reset     = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b1;
        settle();
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_imem_pc", 32'(imem_pc), 32'h0000);
        advance();
        settle();
        chk("mid_restart_valid", 32'(out_valid), 32'd1);
        chk("mid_restart_pc", 32'(out_pc), 32'h0000);
        advance();
        run(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of `instr_memory` and downstream toward decode. It owns the program counter and drives the word address into the instruction memory, whose read is combinational. Each returned instruction is captured, tagged with its PC, and queued in a small prefetch FIFO. The FIFO presents a valid/ready stream to decode. A redirect input from branch/jump resolution flushes the queue and restarts fetch at a new PC.

## Interface
- `DEPTH`, 2 — prefetch FIFO entries; power of two, ≥ 2.
- `RESET_PC`, 16'h0000 — PC loaded on reset.

- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `imem_pc` out 16 — word address to the instruction memory; equals the internal fetch PC.
- `imem_instr` in 16 — instruction returned combinationally for `imem_pc`.
- `out_valid` out 1 — head FIFO entry is presented.
- `out_ready` in 1 — decode accepts the head entry.
- `out_pc` out 16 — PC of the head entry.
- `out_instr` out 16 — instruction of the head entry.
- `redirect` in 1 — flush the FIFO and restart fetch.
- `redirect_pc` in 16 — new fetch PC; sampled when `redirect`=1.
- `count` out $clog2(DEPTH)+1 — current FIFO occupancy.

## Operation
- `pop` = `out_valid` & `out_ready`.
- `push` = !`redirect` & (`count` < DEPTH | `pop`).
- On `push`:
  - write {`imem_pc`, `imem_instr`} at the tail.
  - fetch PC ← fetch PC + 1, modulo 2^16; 16'hFFFF wraps to 16'h0000.
  - The PC unit is words, matching memory indexing.
- With no push, the fetch PC holds.
- `out_valid` = (`count` ≠ 0) & !`redirect`. This is the only combinational path from an input to `out_valid`.
- `out_pc`/`out_instr` always show the head entry. They are don't-care while `out_valid`=0.
- Count update:
  - push & !pop → +1
  - pop & !push → −1
  - push & pop → unchanged
  - Count never exceeds DEPTH and never underflows.
- Read/write pointers wrap modulo DEPTH.
- Redirect has priority over everything else:
  - At the edge: `count` ← 0, pointers ← 0, fetch PC ← `redirect_pc`.
  - No push occurs, and no pop is counted, in the redirect cycle. Decode must treat that cycle as a kill.
- Back-to-back redirects: the last one wins. Each cycle's `redirect_pc` replaces the fetch PC.
- Reset values (all registers, applied on the edge where `reset`=1):
  - fetch PC = RESET_PC
  - `count` = 0, pointers = 0
  - FIFO storage = 0
  - Resulting outputs: `out_valid` = 0, `imem_pc` = RESET_PC, `out_pc` = 0, `out_instr` = 0.
- `reset` overrides `redirect`.
- Reset mid-stream discards all queued entries.

## Timing
- Cycle R is the first cycle with `reset`=0.
  - `imem_pc` = RESET_PC during R.
  - The first push occurs at the end of R.
  - `out_valid` = 1 in cycle R+1 with `out_pc` = RESET_PC.
- Fetch-to-present latency: 1 cycle. There is no bypass from `imem_instr` to `out_instr`.
- Sustained throughput with `out_ready`=1 is 1 instruction/cycle. The FIFO steady state is `count`=1.
- When full with `out_ready`=0:
  - `imem_pc` holds at the next unfetched PC.
  - On the first cycle `out_ready`=1, pop and push happen together, so there is no bubble.
- Redirect asserted in cycle T:
  - `out_valid` = 0 during T.
  - `imem_pc` = `redirect_pc` in T+1, with `out_valid` = 0 in T+1.
  - The first redirected instruction is presented in T+2.
- `out_valid` never depends on `out_ready` (no combinational ready→valid path).

## Test plan
- **Streaming:** model memory as instr = pc ^ 16'hA5A5, `out_ready`=1, RESET_PC=0 → from cycle R+1, `out_pc` = 0, 1, 2, …, one per cycle, each with matching instr; `count` stays 1.
- **Backpressure:** `out_ready`=0 for cycles R+1..R+5 → `count` reaches 2 at R+2 and holds; `imem_pc` holds at 2. After release, the sequence 0, 1, 2, 3 is delivered with no loss, no duplication, and no bubble.
- **Redirect while full:** FIFO holds PCs 4, 5, `out_ready`=1, `redirect`=1, `redirect_pc`=16'h0040 → `out_valid`=0 that cycle; next cycle `count`=0 and `imem_pc`=16'h0040; the following cycle `out_pc`=16'h0040. PCs 4 and 5 are never accepted.
- **Wrap:** redirect to 16'hFFFF → presented PCs are 16'hFFFF, then 16'h0000, then 16'h0001.
- **Back-to-back redirects:** redirect to 16'h0010 then 16'h0020 on consecutive cycles → the first presented PC is 16'h0020; 16'h0010 never appears.
- **Reset mid-stream:** with `count`=2, assert `reset` for one cycle (with `redirect`=1 simultaneously) → next cycle `out_valid`=0, `count`=0, `imem_pc`=RESET_PC; the stream restarts at RESET_PC.
